fft_sample_window: RTL and testbench

//  Parametrised sliding-window sample buffer in front of the FFT core. Shifts in one

---
 rtl/fft_sample_window.sv | 150 +++++++++++++++
 tb/tb_fft_sample_window.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_window.sv
// fft_sample_window: sliding-window sample buffer feeding the FFT core.
// Shifts in one WIDTH-bit sample per accepted strobe and presents all DEPTH
// taps in parallel. Once the window has filled, a one-cycle frame strobe is
// emitted every HOP accepted samples.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   en_i           sample strobe, data_i valid this cycle
//   data_i         sample input
//   clear_i        synchronous flush of taps, counters and flags
//   freeze_i       hold taps; strobed samples are dropped
//   window_o       taps; [WIDTH-1:0] newest, top slice oldest
//   frame_valid_o  one-cycle pulse: window holds a complete new frame
//   primed_o       window filled at least once since reset/clear
//   fill_count_o   samples held, saturates at DEPTH
//   dropped_o      sticky: a sample arrived while frozen
module fft_sample_window #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned HOP   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       clear_i,
    input  logic                       freeze_i,
    output logic [DEPTH*WIDTH-1:0]     window_o,
    output logic                       frame_valid_o,
    output logic                       primed_o,
    output logic [$clog2(DEPTH+1)-1:0] fill_count_o,
    output logic                       dropped_o
);

    localparam int unsigned WIN_W  = DEPTH * WIDTH;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned HOP_W  = $clog2(HOP) + 1;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_FILLING = 2'd1,
        S_PRIMED  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIN_W-1:0]    window_q, window_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [HOP_W-1:0]    hop_q, hop_d;
    logic                frame_q, frame_d;
    logic                primed_q, primed_d;
    logic                dropped_q, dropped_d;

    // A sample is taken only when neither clear nor freeze override it
    logic accept;
    logic last_fill;
    assign accept    = en_i & ~freeze_i & ~clear_i;
    assign last_fill = (fill_q == FILL_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            case (state_q)
                S_EMPTY:   state_d = S_FILLING;
                S_FILLING: state_d = last_fill ? S_PRIMED : S_FILLING;
                S_PRIMED:  state_d = S_PRIMED;
                default:   state_d = S_EMPTY;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        window_d  = window_q;
        fill_d    = fill_q;
        hop_d     = hop_q;
        frame_d   = 1'b0;
        dropped_d = dropped_q;
        primed_d  = (state_d == S_PRIMED);
        if (clear_i) begin
            window_d  = '0;
            fill_d    = '0;
            hop_d     = '0;
            dropped_d = 1'b0;
        end else if (freeze_i) begin
            if (en_i) begin
                dropped_d = 1'b1;
            end
        end else if (en_i) begin
            window_d = {window_q[WIN_W-WIDTH-1:0], data_i};
            if (fill_q != FILL_W'(DEPTH)) begin
                fill_d = fill_q + FILL_W'(1);
            end
            // First frame on entering PRIMED, then one per HOP accepts
            if (state_q == S_FILLING && last_fill) begin
                frame_d = 1'b1;
                hop_d   = '0;
            end else if (state_q == S_PRIMED) begin
                if (hop_q == HOP_W'(HOP - 1)) begin
                    frame_d = 1'b1;
                    hop_d   = '0;
                end else begin
                    hop_d = hop_q + HOP_W'(1);
                end
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q  <= '0;
            fill_q    <= '0;
            hop_q     <= '0;
            frame_q   <= 1'b0;
            primed_q  <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            window_q  <= window_d;
            fill_q    <= fill_d;
            hop_q     <= hop_d;
            frame_q   <= frame_d;
            primed_q  <= primed_d;
            dropped_q <= dropped_d;
        end
    end

    assign window_o      = window_q;
    assign frame_valid_o = frame_q;
    assign primed_o      = primed_q;
    assign fill_count_o  = fill_q;
    assign dropped_o     = dropped_q;

    // accept is consumed via the state machine; keep it referenced explicitly
    logic unused_ok;
    assign unused_ok = accept;

endmodule

// File: tb/tb_fft_sample_window.sv
// Testbench for fft_sample_window: two instances (HOP=16 and HOP=4) share the
// same stimulus and are compared every cycle against a queue-based model.
module tb_fft_sample_window;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned HOP_A = 16;
    localparam int unsigned HOP_B = 4;
    localparam int unsigned WIN_W = DEPTH * WIDTH;
    localparam int unsigned FW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] data;
    logic             clear;
    logic             freeze;

    logic [WIN_W-1:0] win_a, win_b;
    logic             fv_a, fv_b, pr_a, pr_b, dr_a, dr_b;
    logic [FW-1:0]    fc_a, fc_b;

    fft_sample_window #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOP(HOP_A)) u_a (
        .clk(clk), .rst_n(rst_n), .en_i(en), .data_i(data), .clear_i(clear),
        .freeze_i(freeze), .window_o(win_a), .frame_valid_o(fv_a),
        .primed_o(pr_a), .fill_count_o(fc_a), .dropped_o(dr_a)
    );

    fft_sample_window #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOP(HOP_B)) u_b (
        .clk(clk), .rst_n(rst_n), .en_i(en), .data_i(data), .clear_i(clear),
        .freeze_i(freeze), .window_o(win_b), .frame_valid_o(fv_b),
        .primed_o(pr_b), .fill_count_o(fc_b), .dropped_o(dr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    // Model: accepted samples newest-first, accept count since reset/clear
    logic [WIDTH-1:0] hist[$];
    int               n_acc;
    bit               m_drop;
    bit               m_fv_a, m_fv_b;

    task automatic chk(input string name, input logic [WIN_W-1:0] act,
                       input logic [WIN_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        n_acc  = 0;
        m_drop = 1'b0;
        m_fv_a = 1'b0;
        m_fv_b = 1'b0;
    endfunction

    // Effect of the upcoming rising edge given the current inputs
    function automatic void model_edge();
        m_fv_a = 1'b0;
        m_fv_b = 1'b0;
        if (clear) begin
            model_reset();
        end else if (freeze) begin
            if (en) m_drop = 1'b1;
        end else if (en) begin
            hist.push_front(data);
            if (hist.size() > DEPTH) void'(hist.pop_back());
            n_acc++;
            if (n_acc >= int'(DEPTH)) begin
                m_fv_a = ((n_acc - int'(DEPTH)) % int'(HOP_A)) == 0;
                m_fv_b = ((n_acc - int'(DEPTH)) % int'(HOP_B)) == 0;
            end
        end
    endfunction

    function automatic logic [WIN_W-1:0] model_window();
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i < hist.size()) w[i*WIDTH +: WIDTH] = hist[i];
        end
        return w;
    endfunction

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (!done) begin
            logic [WIN_W-1:0] ew;
            int               ef;
            ew = model_window();
            ef = (n_acc > int'(DEPTH)) ? int'(DEPTH) : n_acc;
            chk("window_a", win_a, ew);
            chk("window_b", win_b, ew);
            chk("fill_a", WIN_W'(fc_a), WIN_W'(ef));
            chk("fill_b", WIN_W'(fc_b), WIN_W'(ef));
            chk("primed_a", WIN_W'(pr_a), WIN_W'(n_acc >= int'(DEPTH)));
            chk("primed_b", WIN_W'(pr_b), WIN_W'(n_acc >= int'(DEPTH)));
            chk("dropped_a", WIN_W'(dr_a), WIN_W'(m_drop));
            chk("dropped_b", WIN_W'(dr_b), WIN_W'(m_drop));
            chk("frame_a", WIN_W'(fv_a), WIN_W'(m_fv_a));
            chk("frame_b", WIN_W'(fv_b), WIN_W'(m_fv_b));
        end
    end

    // Drive one cycle's inputs just after the falling edge and advance the model
    task automatic step(input logic e, input logic [WIDTH-1:0] d,
                        input logic c, input logic f);
        @(negedge clk);
        #1;
        en     = e;
        data   = d;
        clear  = c;
        freeze = f;
        model_edge();
    endtask

    task automatic rand_steps(input int n, input int en_mod, input int fr_mod,
                              input int cl_mod);
        for (int i = 0; i < n; i++) begin
            step(($urandom % en_mod) != 0, WIDTH'($urandom),
                 ($urandom % cl_mod) == 0, ($urandom % fr_mod) == 0);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        data   = '0;
        clear  = 1'b0;
        freeze = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Fill with 1,8,15,... : 16th accept primes both instances
        for (int k = 0; k < 16; k++) step(1'b1, WIDTH'(1 + 7 * k), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("fill_newest_lit", WIN_W'(win_a[WIDTH-1:0]), WIN_W'(106));
        chk("fill_oldest_lit", WIN_W'(win_a[WIN_W-1 -: WIDTH]), WIN_W'(1));
        chk("fill_primed_lit", WIN_W'(pr_a), WIN_W'(1));
        chk("fill_frame_lit", WIN_W'(fv_a), WIN_W'(1));
        chk("model_newest_lit", WIN_W'(hist[0]), WIN_W'(106));

        // Overlapped streaming: HOP=4 instance pulses every 4th accept
        rand_steps(24, 1000000, 1000000, 1000000);
        // Gapped strobes: spacing counts accepts, not clocks
        for (int k = 0; k < 20; k++) step(k[0] == 1'b0, WIDTH'($urandom), 1'b0, 1'b0);

        // Freeze for 5 strobes, then resume
        for (int k = 0; k < 5; k++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("freeze_dropped_lit", WIN_W'(dr_a), WIN_W'(1));
        chk("freeze_noframe_lit", WIN_W'(fv_b), WIN_W'(0));
        for (int k = 0; k < 10; k++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);

        // Clear together with a strobe, then refill
        step(1'b1, 8'hAB, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("clear_window_lit", win_a, '0);
        chk("clear_fill_lit", WIN_W'(fc_b), WIN_W'(0));
        chk("clear_dropped_lit", WIN_W'(dr_a), WIN_W'(0));
        for (int k = 0; k < 20; k++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);

        // Random mix including occasional freeze and clear
        rand_steps(300, 4, 16, 64);

        // Asynchronous reset mid-cycle, observed before the next edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        clear = 1'b0;
        freeze = 1'b0;
        #1;
        chk("async_window_lit", win_b, '0);
        chk("async_fill_lit", WIN_W'(fc_a), WIN_W'(0));
        chk("async_primed_lit", WIN_W'(pr_b), WIN_W'(0));
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        rand_steps(80, 3, 20, 100);
        @(negedge clk);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
